// File: rtl/seq_cmp_unit.sv
// Serial multi-mode comparator: computes a-b CHUNK bits per cycle, LSB first, behind valid/ready.
// Optional CMP_FLAGS_EN build adds a registered flags port {ovf, ult, slt, eq}.
module seq_cmp_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef CMP_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [KW-1:0]    k_q, k_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
`ifdef CMP_FLAGS_EN
  logic [3:0]       flags_q, flags_d;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   sub;
  logic             nxt_borrow, nxt_zero, last;
  logic             f_eq, f_ult, f_ovf, f_slt, cond;

  // One chunk of the subtraction; the extra top bit of sub is the borrow out.
  always_comb begin
    a_chunk    = a_q[k_q*CHUNK +: CHUNK];
    b_chunk    = b_q[k_q*CHUNK +: CHUNK];
    sub        = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    nxt_borrow = sub[CHUNK];
    nxt_zero   = zero_q & ~(|sub[CHUNK-1:0]);
    last       = (k_q == KW'(N - 1));
    // Only meaningful on the last chunk, where sub[CHUNK-1] is the MSB of a-b.
    f_eq  = nxt_zero;
    f_ult = nxt_borrow;
    f_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub[CHUNK-1] != a_q[WIDTH-1]);
    f_slt = sub[CHUNK-1] ^ f_ovf;
    case (op_q)
      3'b000:  cond = f_slt;
      3'b001:  cond = f_slt | f_eq;
      3'b010:  cond = ~f_slt & ~f_eq;
      3'b011:  cond = ~f_slt;
      3'b100:  cond = f_eq;
      3'b101:  cond = ~f_eq;
      3'b110:  cond = f_ult;
      default: cond = f_ult | f_eq;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    result_d = result_q;
`ifdef CMP_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          k_d      = '0;
          borrow_d = 1'b0;
          zero_d   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        borrow_d = nxt_borrow;
        zero_d   = nxt_zero;
        k_d      = k_q + KW'(1);
        if (last) begin
          k_d      = '0;
          result_d = {{(WIDTH-1){1'b0}}, cond};
`ifdef CMP_FLAGS_EN
          flags_d  = {f_ovf, f_ult, f_slt, f_eq};
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      k_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      result_q <= '0;
`ifdef CMP_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      result_q <= result_d;
`ifdef CMP_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
`ifdef CMP_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_seq_cmp_unit.sv
// Scoreboard bench for seq_cmp_unit: a CHUNK=4 instance and a degenerate CHUNK=16 instance,
// each with its own expected-result queue and monitor.
module tb_seq_cmp_unit;

  typedef struct {
    logic [15:0] res;
    int          acc;
  } exp_t;

  logic        clk, rst;
  logic        iv0, ir0, ov0, or0;
  logic [15:0] a0, b0, r0;
  logic [2:0]  op0;
  logic        iv1, ir1, ov1, or1;
  logic [15:0] a1, b1, r1;
  logic [2:0]  op1;

  int   checks = 0, failures = 0, cyc = 0;
  int   hold0 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  bit   seen0, seen1, popped0, popped1;

  seq_cmp_unit #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .op(op0),
    .out_valid(ov0), .out_ready(or0), .result(r0));

  seq_cmp_unit #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(or1), .result(r1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic comparisons.
  function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic [2:0] opv);
    bit c;
    case (opv)
      3'd0: c = $signed(av) <  $signed(bv);
      3'd1: c = $signed(av) <= $signed(bv);
      3'd2: c = $signed(av) >  $signed(bv);
      3'd3: c = $signed(av) >= $signed(bv);
      3'd4: c = av == bv;
      3'd5: c = av != bv;
      3'd6: c = av <  bv;
      default: c = av <= bv;
    endcase
    return {15'd0, c};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic send(input int id, input logic [15:0] av, input logic [15:0] bv,
                      input logic [2:0] opv);
    int   n;
    exp_t e;
    @(negedge clk);
    if (id == 0) begin iv0 = 1; a0 = av; b0 = bv; op0 = opv; end
    else         begin iv1 = 1; a1 = av; b1 = bv; op1 = opv; end
    n = 0;
    while (((id == 0) ? !ir0 : !ir1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 0, 1);
      iv0 = 0; iv1 = 0;
      return;
    end
    e.res = model(av, bv, opv);
    e.acc = cyc + 1;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    // Scramble request inputs while the unit is busy; none of it may be taken.
    repeat ((id == 0) ? 4 : 1) begin
      if (id == 0) begin
        iv0 = 1'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); op0 = 3'($urandom);
      end else begin
        iv1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom); op1 = 3'($urandom);
      end
      @(posedge clk);
      #1;
    end
    if (id == 0) iv0 = 0; else iv1 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
  endtask

  // Monitor for the CHUNK=4 instance (N=4).
  initial begin
    seen0 = 0; popped0 = 0; or0 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen0 = 0; popped0 = 0; or0 = 0;
      end else begin
        if (popped0) chk("ov_drop0", ov0, 0);
        popped0 = 0;
        if (ov0) begin
          if (q0.size() == 0) begin
            chk("spurious_ov0", ov0, 0);
            or0 = 1;
          end else begin
            e0 = q0[0];
            if (!seen0) chk("latency0", cyc - e0.acc, 4);
            seen0 = 1;
            chk("result0", r0, e0.res);
            chk("in_ready_done0", ir0, 0);
            if (hold0 > 0) begin or0 = 0; hold0--; end
            else or0 = 1'($urandom_range(0, 1));
            if (or0) begin void'(q0.pop_front()); seen0 = 0; popped0 = 1; end
          end
        end else or0 = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor for the CHUNK=16 instance (N=1).
  initial begin
    seen1 = 0; popped1 = 0; or1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen1 = 0; popped1 = 0; or1 = 0;
      end else begin
        if (popped1) chk("ov_drop1", ov1, 0);
        popped1 = 0;
        if (ov1) begin
          if (q1.size() == 0) begin
            chk("spurious_ov1", ov1, 0);
            or1 = 1;
          end else begin
            e1 = q1[0];
            if (!seen1) chk("latency1", cyc - e1.acc, 1);
            seen1 = 1;
            chk("result1", r1, e1.res);
            chk("in_ready_done1", ir1, 0);
            or1 = 1'($urandom_range(0, 1));
            if (or1) begin void'(q1.pop_front()); seen1 = 0; popped1 = 1; end
          end
        end else or1 = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1; iv0 = 0; a0 = 0; b0 = 0; op0 = 0; iv1 = 0; a1 = 0; b1 = 0; op1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", ir0, 1);  chk("rst_out_valid0", ov0, 0);  chk("rst_result0", r0, 0);
    chk("rst_in_ready1", ir1, 1);  chk("rst_out_valid1", ov1, 0);  chk("rst_result1", r1, 0);
    rst = 0;

    send(0, 16'h7FFF, 16'h8000, 3'd1);
    send(0, 16'h7FFF, 16'h8000, 3'd6);
    send(0, 16'h8000, 16'h0001, 3'd0);
    send(0, 16'h1234, 16'h1234, 3'd1);
    send(0, 16'h1234, 16'h1234, 3'd0);
    send(0, 16'h1234, 16'h1234, 3'd4);
    send(0, 16'h1234, 16'h1234, 3'd5);
    send(0, 16'h1234, 16'h1234, 3'd3);
    drain();

    // Backpressure: hold the result three cycles while a new request waits.
    hold0 = 3;
    send(0, 16'h0005, 16'hFFFB, 3'd2);
    send(0, 16'h0003, 16'h0003, 3'd7);
    drain();

    // Reset during the second BUSY cycle aborts the op.
    @(negedge clk);
    iv0 = 1; a0 = 16'h5555; b0 = 16'h1111; op0 = 3'd5;
    @(posedge clk);
    #1 iv0 = 0;
    @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    @(negedge clk) rst = 0;
    chk("abort_in_ready", ir0, 1);
    chk("abort_out_valid", ov0, 0);
    chk("abort_result", r0, 0);
    send(0, 16'hFFFF, 16'h0000, 3'd7);

    send(1, 16'hFFFF, 16'h0000, 3'd0);
    send(1, 16'h8000, 16'h0001, 3'd0);
    drain();

    for (int i = 0; i < 120; i++) begin
      ra = rnd16();
      rb = ($urandom_range(0, 3) == 0) ? ra : rnd16();
      send(0, ra, rb, 3'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      ra = rnd16();
      rb = ($urandom_range(0, 3) == 0) ? ra : rnd16();
      send(1, ra, rb, 3'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
